attopu_sequencer: RTL and testbench

ATTOPU_SEQUENCER -- requirements
Module: attopu_sequencer

---
 rtl/attopu_pkg.sv | 34 +++
 rtl/attopu_sequencer.sv | 156 +++++++++++++++
 tb/tb_attopu_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/attopu_pkg.sv
// -----------------------------------------------------------------------------
// attopu_pkg
// Shared definitions for the attopu core control path: the sequencer state
// encoding, the major opcode field values (ir[15:13]) and the decoder's
// branch-taken next-PC select code.
// -----------------------------------------------------------------------------
package attopu_pkg;

  // Sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } seq_state_e;

  // Major opcode field values (ir[15:13]).
  localparam logic [2:0] OP_ALU = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_LDR = 3'b011;
  localparam logic [2:0] OP_STR = 3'b101;
  localparam logic [2:0] OP_BR  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  // Decoder next-PC select value meaning "branch taken".
  localparam logic [1:0] PC_SEL_TAKEN = 2'b01;

  // True when the instruction word belongs to the ALU group (updates flags).
  function automatic logic is_alu_op(input logic [15:0] instr);
    return (instr[15:13] == OP_ALU);
  endfunction

endpackage : attopu_pkg

// File: rtl/attopu_sequencer.sv
// -----------------------------------------------------------------------------
// attopu_sequencer
// Multi-cycle control sequencer for the attopu core. Steps every instruction
// through FETCH -> DECODE -> [MEM] -> WB over a shared single-port memory, and
// parks in HALT until a run request resumes execution.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   run                   resume request (only honoured in HALT)
//   mem_req/we/addr/wdata shared memory request channel
//   mem_ack, mem_rdata    one-cycle completion strobe and read data
//   ir                    instruction register, feeds the external decoder
//   dec_*                 decoder controls derived from ir
//   rf_addr_data          register-file read port used as indirect address
//   rf_store_data         register-file read port used as store data
//   pc, mdr               program counter, memory data register
//   rf_we, flag_we        write-back strobes
//   halted, instret       status: in HALT, instruction retired pulse
// -----------------------------------------------------------------------------
module attopu_sequencer
  import attopu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] ir,
  input  logic [1:0]  dec_next_pc_sel,
  input  logic        dec_halt,
  input  logic        dec_mem_we,
  input  logic        dec_daddr_sel,
  input  logic        dec_rf_we,
  input  logic [15:0] dec_addr,
  input  logic [15:0] rf_addr_data,
  input  logic [15:0] rf_store_data,
  output logic [15:0] pc,
  output logic [15:0] mdr,
  output logic        rf_we,
  output logic        flag_we,
  output logic        halted,
  output logic        instret
);

  seq_state_e  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] mdr_q, mdr_d;

  // Next-state and datapath register update for the sequencer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (dec_halt) begin
          state_d = ST_HALT;
        end else if (dec_daddr_sel) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          // Only loads capture read data; a store ack leaves mdr alone.
          if (!dec_mem_we) begin
            mdr_d = mem_rdata;
          end else begin
            mdr_d = mdr_q;
          end
          state_d = ST_WB;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        // Branch offset is relative to the branch instruction itself;
        // both sums wrap modulo 2^16.
        if (dec_next_pc_sel == PC_SEL_TAKEN) begin
          pc_d = pc_q + dec_addr;
        end else begin
          pc_d = pc_q + 16'd1;
        end
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        if (run) begin
          pc_d    = pc_q + 16'd1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Sequencer state and datapath registers with asynchronous reset; a reset
  // mid-request simply abandons the transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      mdr_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
    end
  end

  // Memory channel and status outputs decoded from the current state. The
  // MEM-phase address/data come from register-file ports that cannot change
  // while the request is outstanding, so they stay stable until the ack.
  always_comb begin
    mem_req   = (state_q == ST_FETCH) || (state_q == ST_MEM);
    mem_we    = (state_q == ST_MEM) && dec_mem_we;
    if (state_q == ST_MEM) begin
      mem_addr  = rf_addr_data;
      mem_wdata = rf_store_data;
    end else begin
      mem_addr  = pc_q;
      mem_wdata = 16'h0000;
    end
    rf_we   = (state_q == ST_WB) && dec_rf_we;
    flag_we = (state_q == ST_WB) && is_alu_op(ir_q);
    instret = (state_q == ST_WB) || ((state_q == ST_HALT) && run);
    halted  = (state_q == ST_HALT);
  end

  assign pc  = pc_q;
  assign ir  = ir_q;
  assign mdr = mdr_q;

endmodule : attopu_sequencer

// File: tb/tb_attopu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_attopu_sequencer
// Directed self-checking bench for attopu_sequencer. The bench plays the roles
// of memory, decoder and register file; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_attopu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ir;
  logic [1:0]  dec_next_pc_sel;
  logic        dec_halt;
  logic        dec_mem_we;
  logic        dec_daddr_sel;
  logic        dec_rf_we;
  logic [15:0] dec_addr;
  logic [15:0] rf_addr_data;
  logic [15:0] rf_store_data;
  logic [15:0] pc;
  logic [15:0] mdr;
  logic        rf_we;
  logic        flag_we;
  logic        halted;
  logic        instret;

  int checks = 0;
  int errors = 0;

  attopu_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .run             (run),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .ir              (ir),
    .dec_next_pc_sel (dec_next_pc_sel),
    .dec_halt        (dec_halt),
    .dec_mem_we      (dec_mem_we),
    .dec_daddr_sel   (dec_daddr_sel),
    .dec_rf_we       (dec_rf_we),
    .dec_addr        (dec_addr),
    .rf_addr_data    (rf_addr_data),
    .rf_store_data   (rf_store_data),
    .pc              (pc),
    .mdr             (mdr),
    .rf_we           (rf_we),
    .flag_we         (flag_we),
    .halted          (halted),
    .instret         (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait fetch of a non-memory instruction through DECODE and WB.
  task automatic exec_nomem(input logic [15:0] instr, input logic [1:0] sel,
                            input logic [15:0] off);
    mem_ack   = 1'b1;
    mem_rdata = instr;
    step();
    mem_ack         = 1'b0;
    dec_halt        = 1'b0;
    dec_daddr_sel   = 1'b0;
    dec_next_pc_sel = sel;
    dec_addr        = off;
    step();
    step();
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000;
    dec_next_pc_sel = 2'b00; dec_halt = 1'b0; dec_mem_we = 1'b0;
    dec_daddr_sel = 1'b0; dec_rf_we = 1'b0; dec_addr = 16'h0000;
    rf_addr_data = 16'h0000; rf_store_data = 16'h0000;

    // Reset state
    #12;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_mdr", mdr, 16'h0000);
    chk("rst_strobes", {rf_we, flag_we, instret, halted}, 16'h0000);
    rst_n = 1'b1;

    // ALU op at 0x0000, zero-wait: 3 cycles
    chk("f1_req", mem_req, 16'h0001);
    chk("f1_addr", mem_addr, 16'h0000);
    chk("f1_we", mem_we, 16'h0000);
    mem_ack = 1'b1; mem_rdata = 16'h0123;
    step();
    mem_ack = 1'b0;
    chk("alu_ir", ir, 16'h0123);
    chk("alu_dec_req", mem_req, 16'h0000);
    chk("alu_dec_instret", instret, 16'h0000);
    dec_rf_we = 1'b1; dec_daddr_sel = 1'b0; dec_next_pc_sel = 2'b00;
    step();
    chk("alu_wb_rfwe", rf_we, 16'h0001);
    chk("alu_wb_flagwe", flag_we, 16'h0001);
    chk("alu_wb_instret", instret, 16'h0001);
    chk("alu_wb_req", mem_req, 16'h0000);
    step();
    chk("alu_pc", pc, 16'h0001);
    chk("alu_instret_clr", instret, 16'h0000);
    chk("alu_next_addr", mem_addr, 16'h0001);

    // LDR with two wait cycles
    mem_ack = 1'b1; mem_rdata = 16'h6000;
    step();
    mem_ack = 1'b0;
    dec_daddr_sel = 1'b1; dec_mem_we = 1'b0; dec_rf_we = 1'b1; rf_addr_data = 16'h0040;
    step();
    chk("ldr_m0_req", mem_req, 16'h0001);
    chk("ldr_m0_addr", mem_addr, 16'h0040);
    chk("ldr_m0_we", mem_we, 16'h0000);
    step();
    chk("ldr_m1_addr", mem_addr, 16'h0040);
    step();
    chk("ldr_m2_addr", mem_addr, 16'h0040);
    chk("ldr_m2_req", mem_req, 16'h0001);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step();
    mem_ack = 1'b0;
    chk("ldr_mdr", mdr, 16'hBEEF);
    chk("ldr_wb_rfwe", rf_we, 16'h0001);
    chk("ldr_wb_flagwe", flag_we, 16'h0000);
    chk("ldr_wb_instret", instret, 16'h0001);
    step();
    chk("ldr_pc", pc, 16'h0002);

    // STR
    mem_ack = 1'b1; mem_rdata = 16'hA000;
    step();
    mem_ack = 1'b0;
    dec_daddr_sel = 1'b1; dec_mem_we = 1'b1; dec_rf_we = 1'b0;
    rf_addr_data = 16'h0010; rf_store_data = 16'h1234;
    step();
    chk("str_we", mem_we, 16'h0001);
    chk("str_addr", mem_addr, 16'h0010);
    chk("str_wdata", mem_wdata, 16'h1234);
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    step();
    mem_ack = 1'b0;
    chk("str_wb_rfwe", rf_we, 16'h0000);
    chk("str_mdr_hold", mdr, 16'hBEEF);
    chk("str_wb_instret", instret, 16'h0001);
    step();
    chk("str_pc", pc, 16'h0003);
    dec_mem_we = 1'b0;

    // Branches and wrap
    exec_nomem(16'h0000, 2'b00, 16'h0000);
    exec_nomem(16'h0000, 2'b00, 16'h0000);
    chk("pc_5", pc, 16'h0005);
    exec_nomem(16'hC000, 2'b01, 16'hFFFD);
    chk("br_taken", pc, 16'h0002);
    exec_nomem(16'hC000, 2'b01, 16'hFFFD);
    chk("br_to_ffff", pc, 16'hFFFF);
    exec_nomem(16'hC000, 2'b10, 16'h0010);
    chk("pc_wrap", pc, 16'h0000);

    // HALT, spurious ack ignored, run resumes
    mem_ack = 1'b1; mem_rdata = 16'hE000;
    step();
    mem_ack = 1'b0; dec_halt = 1'b1;
    step();
    chk("hlt_halted", halted, 16'h0001);
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      chk("hlt_no_req", mem_req, 16'h0000);
      step();
    end
    mem_ack = 1'b0;
    chk("hlt_pc_hold", pc, 16'h0000);
    chk("hlt_ir_hold", ir, 16'hE000);
    chk("hlt_no_instret", instret, 16'h0000);
    run = 1'b1;
    #1;
    chk("run_instret", instret, 16'h0001);
    step();
    run = 1'b0; dec_halt = 1'b0;
    chk("run_pc", pc, 16'h0001);
    chk("run_halted", halted, 16'h0000);
    chk("run_fetch_req", mem_req, 16'h0001);

    // run outside HALT has no effect
    run = 1'b1;
    step();
    run = 1'b0;
    chk("run_ign_pc", pc, 16'h0001);
    chk("run_ign_addr", mem_addr, 16'h0001);
    chk("run_ign_req", mem_req, 16'h0001);

    // Reset during MEM wait
    mem_ack = 1'b1; mem_rdata = 16'h6000;
    step();
    mem_ack = 1'b0; dec_daddr_sel = 1'b1; dec_mem_we = 1'b0; rf_addr_data = 16'h0040;
    step();
    step();
    chk("pre_rst_addr", mem_addr, 16'h0040);
    rst_n = 1'b0;
    #1;
    chk("mr_pc", pc, 16'h0000);
    chk("mr_ir", ir, 16'h0000);
    chk("mr_mdr", mdr, 16'h0000);
    chk("mr_addr", mem_addr, 16'h0000);
    chk("mr_strobes", {mem_we, rf_we, flag_we, instret, halted}, 16'h0000);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step();
    chk("mr_mdr_held", mdr, 16'h0000);
    chk("mr_ir_held", ir, 16'h0000);
    mem_ack = 1'b0; dec_daddr_sel = 1'b0;
    rst_n = 1'b1;
    chk("rel_req", mem_req, 16'h0001);
    chk("rel_addr", mem_addr, 16'h0000);
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    step();
    mem_rdata = 16'hFFFF;
    chk("idle_req", mem_req, 16'h0000);
    step();
    chk("idle_ack_ir", ir, 16'h1111);
    chk("idle_ack_mdr", mdr, 16'h0000);
    mem_ack = 1'b0;
    step();
    chk("rel_pc", pc, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_attopu_sequencer
